// File: rtl/iobus_pkg.sv
// Shared types and widths for the two-requester IO bus arbiter.
package iobus_pkg;

  localparam int IOBUS_AW = 32;
  localparam int IOBUS_DW = 32;

  // One bit per owner, so each grant is a flop output rather than a decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/iobus_arbiter_if.sv
// Request/grant and shared-bus signals between the two requesters, the arbiter and the IO bus.
interface iobus_arbiter_if;
  import iobus_pkg::*;

  logic                REQ0;
  logic                REQ1;
  logic [IOBUS_AW-1:0] ADDR0;
  logic [IOBUS_AW-1:0] ADDR1;
  logic [IOBUS_DW-1:0] WDATA0;
  logic [IOBUS_DW-1:0] WDATA1;
  logic                WR0;
  logic                WR1;
  logic                GNT0;
  logic                GNT1;
  logic [IOBUS_DW-1:0] RDATA;
  logic [IOBUS_AW-1:0] IOBUS_ADDR;
  logic [IOBUS_DW-1:0] IOBUS_OUT;
  logic                IOBUS_WR;
  logic [IOBUS_DW-1:0] IOBUS_IN;
  logic                TIMEOUT;

  modport master (
    output REQ0, REQ1, ADDR0, ADDR1, WDATA0, WDATA1, WR0, WR1, IOBUS_IN,
    input  GNT0, GNT1, RDATA, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, TIMEOUT
  );

  modport slave (
    input  REQ0, REQ1, ADDR0, ADDR1, WDATA0, WDATA1, WR0, WR1, IOBUS_IN,
    output GNT0, GNT1, RDATA, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, TIMEOUT
  );

endinterface

// File: rtl/iobus_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the one not served last.
module iobus_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);

  // Winner select
  always_comb begin
    winner = 1'b0;
    case ({req1, req0})
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/iobus_arbiter.sv
// Two-requester IO bus arbiter (MCU = 0, debug master = 1) with round-robin ties.
// Define IOBUS_ARB_TIMEOUT_EN to force a handoff after TIMEOUT_CYCLES contended cycles.
module iobus_arbiter
  import iobus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           CLK,
  input  logic           RESET_N,
  iobus_arbiter_if.slave bus
);

  arb_state_t          state_r;
  logic                last_r;
  logic                pick_s;
  logic [IOBUS_AW-1:0] addr_s;
  logic [IOBUS_DW-1:0] wdata_s;
  logic                wr_s;

`ifdef IOBUS_ARB_TIMEOUT_EN
  localparam int            CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt_r;
  logic             timeout_r;
`endif

  iobus_rr_pick u_pick (
    .req0   (bus.REQ0),
    .req1   (bus.REQ1),
    .last   (last_r),
    .winner (pick_s)
  );

  // Ownership FSM, round-robin pointer, hold counter and timeout pulse
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
`ifdef IOBUS_ARB_TIMEOUT_EN
      hold_cnt_r <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
`ifdef IOBUS_ARB_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            state_r    <= pick_s ? OWN1 : OWN0;
            last_r     <= pick_s;
`ifdef IOBUS_ARB_TIMEOUT_EN
            hold_cnt_r <= '0;
`endif
          end
        end
        OWN0: begin
          if (!bus.REQ0) begin
            if (bus.REQ1) begin
              state_r    <= OWN1;
              last_r     <= 1'b1;
`ifdef IOBUS_ARB_TIMEOUT_EN
              hold_cnt_r <= '0;
`endif
            end else begin
              state_r <= IDLE;
            end
          end
`ifdef IOBUS_ARB_TIMEOUT_EN
          else if (bus.REQ1) begin
            if (hold_cnt_r == CNT_MAX) begin
              state_r    <= OWN1;
              last_r     <= 1'b1;
              hold_cnt_r <= '0;
              timeout_r  <= 1'b1;
            end else begin
              hold_cnt_r <= hold_cnt_r + 1'b1;
            end
          end
`endif
        end
        OWN1: begin
          if (!bus.REQ1) begin
            if (bus.REQ0) begin
              state_r    <= OWN0;
              last_r     <= 1'b0;
`ifdef IOBUS_ARB_TIMEOUT_EN
              hold_cnt_r <= '0;
`endif
            end else begin
              state_r <= IDLE;
            end
          end
`ifdef IOBUS_ARB_TIMEOUT_EN
          else if (bus.REQ0) begin
            if (hold_cnt_r == CNT_MAX) begin
              state_r    <= OWN0;
              last_r     <= 1'b0;
              hold_cnt_r <= '0;
              timeout_r  <= 1'b1;
            end else begin
              hold_cnt_r <= hold_cnt_r + 1'b1;
            end
          end
`endif
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Shared-bus mux; a write strobe only passes from the current owner
  always_comb begin
    addr_s  = '0;
    wdata_s = '0;
    wr_s    = 1'b0;
    case (state_r)
      OWN0: begin
        addr_s  = bus.ADDR0;
        wdata_s = bus.WDATA0;
        wr_s    = bus.WR0 & bus.REQ0;
      end
      OWN1: begin
        addr_s  = bus.ADDR1;
        wdata_s = bus.WDATA1;
        wr_s    = bus.WR1 & bus.REQ1;
      end
      default: begin
        addr_s  = '0;
        wdata_s = '0;
        wr_s    = 1'b0;
      end
    endcase
  end

  assign bus.GNT0       = (state_r == OWN0);
  assign bus.GNT1       = (state_r == OWN1);
  assign bus.RDATA      = bus.IOBUS_IN;
  assign bus.IOBUS_ADDR = addr_s;
  assign bus.IOBUS_OUT  = wdata_s;
  assign bus.IOBUS_WR   = wr_s;
`ifdef IOBUS_ARB_TIMEOUT_EN
  assign bus.TIMEOUT    = timeout_r;
`else
  assign bus.TIMEOUT    = 1'b0;
`endif

endmodule

// File: tb/tb_iobus_arbiter.sv
// Directed bench for iobus_arbiter: ownership model checked every cycle plus literal spot checks.
module tb_iobus_arbiter;

`ifdef IOBUS_ARB_TIMEOUT_EN
  localparam int TC     = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TC     = 256;
  localparam bit TMO_EN = 1'b0;
`endif

  logic CLK;
  logic RESET_N;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  iobus_arbiter_if bus ();

  iobus_arbiter #(.TIMEOUT_CYCLES(TC)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 2 = nobody; last = requester most recently granted
  int       own_m;
  int       last_m;
  int       hold_m;
  bit       tmo_m;
  int       nxt_own;
  int       nxt_hold;
  bit       nxt_tmo;
  bit [1:0] req_v;

  assign req_v = {bus.REQ1, bus.REQ0};

  always_comb begin
    nxt_own  = own_m;
    nxt_hold = hold_m;
    nxt_tmo  = 1'b0;
    if (own_m == 2) begin
      if (req_v == 2'b11)  nxt_own = 1 - last_m;
      else if (req_v[0])   nxt_own = 0;
      else if (req_v[1])   nxt_own = 1;
    end else if (!req_v[own_m]) begin
      nxt_own = req_v[1 - own_m] ? 1 - own_m : 2;
    end else if (TMO_EN && req_v[1 - own_m]) begin
      if (hold_m == TC - 1) begin
        nxt_own = 1 - own_m;
        nxt_tmo = 1'b1;
      end else begin
        nxt_hold = hold_m + 1;
      end
    end
    if (nxt_own != own_m && nxt_own != 2) nxt_hold = 0;
  end

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      own_m  <= 2;
      last_m <= 1;
      hold_m <= 0;
      tmo_m  <= 1'b0;
    end else begin
      own_m  <= nxt_own;
      last_m <= (nxt_own != 2) ? nxt_own : last_m;
      hold_m <= nxt_hold;
      tmo_m  <= nxt_tmo;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    logic [31:0] e_addr;
    logic [31:0] e_out;
    logic        e_wr;
    e_addr = (own_m == 0) ? bus.ADDR0  : (own_m == 1) ? bus.ADDR1  : 32'h0;
    e_out  = (own_m == 0) ? bus.WDATA0 : (own_m == 1) ? bus.WDATA1 : 32'h0;
    e_wr   = (own_m == 0) ? (bus.WR0 & bus.REQ0) : (own_m == 1) ? (bus.WR1 & bus.REQ1) : 1'b0;
    check("m_gnt0",  {31'h0, bus.GNT0},     {31'h0, own_m == 0});
    check("m_gnt1",  {31'h0, bus.GNT1},     {31'h0, own_m == 1});
    check("m_addr",  bus.IOBUS_ADDR,        e_addr);
    check("m_out",   bus.IOBUS_OUT,         e_out);
    check("m_wr",    {31'h0, bus.IOBUS_WR}, {31'h0, e_wr});
    check("m_rdata", bus.RDATA,             bus.IOBUS_IN);
    check("m_tmo",   {31'h0, bus.TIMEOUT},  {31'h0, tmo_m});
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0; bus.WR0 = 1'b0; bus.WR1 = 1'b0;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  initial begin
    bit lost_gnt;
    bit seen_tmo;
    RESET_N    = 1'b0;
    bus.REQ0   = 1'b0;  bus.REQ1   = 1'b0;
    bus.ADDR0  = 32'h0; bus.ADDR1  = 32'h0;
    bus.WDATA0 = 32'h0; bus.WDATA1 = 32'h0;
    bus.WR0    = 1'b0;  bus.WR1    = 1'b0;
    bus.IOBUS_IN = 32'h0;
    tick();
    tick();
    check("rst_gnt0", {31'h0, bus.GNT0},     32'h0);
    check("rst_gnt1", {31'h0, bus.GNT1},     32'h0);
    check("rst_wr",   {31'h0, bus.IOBUS_WR}, 32'h0);
    check("rst_addr", bus.IOBUS_ADDR,        32'h0);
    check("rst_tmo",  {31'h0, bus.TIMEOUT},  32'h0);

    // First grant after reset release, with a write
    RESET_N = 1'b1;
    tick();
    bus.REQ0 = 1'b1; bus.ADDR0 = 32'h11080000; bus.WR0 = 1'b1; bus.WDATA0 = 32'd5;
    #1 check("t1_gnt0_early", {31'h0, bus.GNT0}, 32'h0);
    check("t1_wr_early", {31'h0, bus.IOBUS_WR}, 32'h0);
    tick();
    #1 check("t1_gnt0",  {31'h0, bus.GNT0},     32'h1);
    check("t1_wr",   {31'h0, bus.IOBUS_WR}, 32'h1);
    check("t1_addr", bus.IOBUS_ADDR,        32'h11080000);
    check("t1_out",  bus.IOBUS_OUT,         32'h5);
    bus.ADDR0 = 32'h11000000; bus.WR0 = 1'b0; bus.IOBUS_IN = 32'h0000BEEF;
    #1 check("rdata_same_cycle", bus.RDATA, 32'h0000BEEF);
    check("rdata_addr", bus.IOBUS_ADDR, 32'h11000000);

    // Round-robin ties and bubble-free handoff
    do_reset();
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    tick();
    #1 check("tie1_gnt0", {31'h0, bus.GNT0}, 32'h1);
    check("tie1_gnt1", {31'h0, bus.GNT1}, 32'h0);
    bus.REQ0 = 1'b0;
    tick();
    #1 check("handoff_gnt1", {31'h0, bus.GNT1}, 32'h1);
    check("handoff_gnt0", {31'h0, bus.GNT0}, 32'h0);
    bus.REQ1 = 1'b0;
    tick();
    #1 check("idle_gnt1", {31'h0, bus.GNT1}, 32'h0);
    bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
    tick();
    #1 check("tie2_gnt0", {31'h0, bus.GNT0}, 32'h1);

    // Non-owner write strobe and address must not leak
    bus.WR0 = 1'b0; bus.ADDR0 = 32'h11000004; bus.WDATA0 = 32'h0;
    bus.WR1 = 1'b1; bus.ADDR1 = 32'h22220000; bus.WDATA1 = 32'hDEAD;
    #1 check("leak_wr",   {31'h0, bus.IOBUS_WR}, 32'h0);
    check("leak_addr", bus.IOBUS_ADDR, 32'h11000004);
    check("leak_out",  bus.IOBUS_OUT,  32'h0);
    tick();
    bus.WR0 = 1'b1; bus.WDATA0 = 32'h77;
    #1 check("own_wr",  {31'h0, bus.IOBUS_WR}, 32'h1);
    check("own_out", bus.IOBUS_OUT, 32'h77);

    // Contended hold: forced handoff with the macro, indefinite hold without
    do_reset();
    bus.REQ0 = 1'b1;
    tick();
    #1 check("hold_gnt0", {31'h0, bus.GNT0}, 32'h1);
    bus.REQ1 = 1'b1;
`ifdef IOBUS_ARB_TIMEOUT_EN
    repeat (7) tick();
    #1 check("tmo_pre_gnt0", {31'h0, bus.GNT0},    32'h1);
    check("tmo_pre_pulse", {31'h0, bus.TIMEOUT}, 32'h0);
    tick();
    #1 check("tmo_gnt1",  {31'h0, bus.GNT1},    32'h1);
    check("tmo_pulse", {31'h0, bus.TIMEOUT}, 32'h1);
    tick();
    #1 check("tmo_pulse_end", {31'h0, bus.TIMEOUT}, 32'h0);
    check("tmo_gnt1_hold", {31'h0, bus.GNT1},    32'h1);
`else
    lost_gnt = 1'b0;
    seen_tmo = 1'b0;
    repeat (1000) begin
      tick();
      if (bus.TIMEOUT) seen_tmo = 1'b1;
      if (!bus.GNT0)   lost_gnt = 1'b1;
    end
    check("hold1000_lost", {31'h0, lost_gnt}, 32'h0);
    check("hold1000_tmo",  {31'h0, seen_tmo}, 32'h0);
`endif

    // Asynchronous reset in the middle of an OWN1 write
    do_reset();
    bus.REQ1 = 1'b1; bus.WR1 = 1'b1; bus.ADDR1 = 32'h11080010; bus.WDATA1 = 32'd9;
    tick();
    #1 check("rw_gnt1", {31'h0, bus.GNT1},     32'h1);
    check("rw_wr",   {31'h0, bus.IOBUS_WR}, 32'h1);
    RESET_N = 1'b0;
    #1 check("rw_rst_gnt1", {31'h0, bus.GNT1},     32'h0);
    check("rw_rst_wr",   {31'h0, bus.IOBUS_WR}, 32'h0);
    check("rw_rst_addr", bus.IOBUS_ADDR,        32'h0);
    tick();
    #1 check("rw_in_rst_gnt1", {31'h0, bus.GNT1}, 32'h0);
    bus.REQ1 = 1'b0;
    RESET_N  = 1'b1;
    tick();
    bus.REQ1 = 1'b1;
    #1 check("rw_rel_gnt1_early", {31'h0, bus.GNT1}, 32'h0);
    tick();
    #1 check("rw_rel_gnt1", {31'h0, bus.GNT1}, 32'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/iobus_arbiter.md
IOBUS_ARBITER -- requirements
Module: iobus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: maximum grant hold, in cycles, while the other requester waits (used only with the Configuration macro).
REQ-002 CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-003 RESET_N  input  1  reset, asynchronous and active-low.
REQ-004 REQ0, REQ1  input  1 each  bus request; requester 0 is the MCU, requester 1 is the programmer/debug master.
REQ-005 ADDR0, ADDR1  input  32 each  requester address.
REQ-006 WDATA0, WDATA1  input  32 each  requester write data.
REQ-007 WR0, WR1  input  1 each  requester write strobe.
REQ-008 GNT0, GNT1  output  1 each  registered grant; at most one high in any cycle.
REQ-009 RDATA  output  32  read data to both requesters, equal to IOBUS_IN combinationally.
REQ-010 IOBUS_ADDR, IOBUS_OUT  output  32 each  shared bus address and write data.
REQ-011 IOBUS_WR  output  1  shared bus write strobe.
REQ-012 IOBUS_IN  input  32  shared bus read data.
REQ-013 TIMEOUT  output  1  one-cycle pulse on a forced handoff.

Function
REQ-014 The FSM SHALL have three states: IDLE, OWN0 and OWN1; GNTn SHALL be high exactly in state OWNn.
REQ-015 IDLE -> OWNn SHALL occur on the cycle after REQn is sampled high, giving one cycle of grant latency.
REQ-016 When both requests are sampled high in IDLE, the requester not granted most recently SHALL win (round-robin pointer LAST).
REQ-017 OWNn SHALL be held while REQn stays high.
REQ-018 When REQn is sampled low in OWNn and the other request is high, the FSM SHALL move directly to OWN(other) with no IDLE bubble.
REQ-019 When REQn is sampled low in OWNn and the other request is low, the FSM SHALL move to IDLE.
REQ-020 LAST SHALL update to n on every entry into OWNn.
REQ-021 In OWNn, IOBUS_ADDR, IOBUS_OUT and IOBUS_WR SHALL equal ADDRn, WDATAn and (WRn AND REQn), all combinationally.
REQ-022 In IDLE, IOBUS_ADDR and IOBUS_OUT SHALL be 0 and IOBUS_WR SHALL be 0.
REQ-023 A WRn asserted without GNTn SHALL never reach IOBUS_WR.
REQ-024 Requesters SHALL treat an access as complete on any cycle where both REQn and GNTn are high (zero wait states).

Reset
REQ-025 While RESET_N is low: state SHALL be IDLE, LAST SHALL be 1 (so requester 0 wins the first tie), GNT0 = GNT1 = 0, IOBUS_WR = 0, IOBUS_ADDR = IOBUS_OUT = 0, TIMEOUT = 0, and the hold counter SHALL be 0.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously) with no bus write in that cycle.
REQ-027 Reset deassertion SHALL take effect at the next posedge CLK.

Configuration
REQ-028 With IOBUS_ARB_TIMEOUT_EN defined: a counter SHALL clear on every OWN entry and increment each cycle in OWNn while the other request is high.
REQ-029 With IOBUS_ARB_TIMEOUT_EN defined: when that counter reaches TIMEOUT_CYCLES-1, the next state SHALL be OWN(other) and TIMEOUT SHALL pulse for one cycle.
REQ-030 With IOBUS_ARB_TIMEOUT_EN defined: the counter SHALL hold its value while the other request is low.
REQ-031 With IOBUS_ARB_TIMEOUT_EN defined: the counter width SHALL be $clog2(TIMEOUT_CYCLES).
REQ-032 Without IOBUS_ARB_TIMEOUT_EN: no counter SHALL exist, a grant SHALL be held indefinitely, and TIMEOUT SHALL be tied to 0.

Structure
REQ-033 A shared package iobus_pkg SHALL hold the arb_state_t enum (IDLE, OWN0, OWN1) and the IOBUS address/data width constants (32).
REQ-034 One sub-module SHALL exist: iobus_rr_pick, a combinational two-way round-robin selector taking REQ0, REQ1 and LAST and returning the winner index.
REQ-035 No other sub-modules SHALL exist.

Verification
REQ-036 Reset release, then REQ0=1: GNT0=1 on the second edge; ADDR0=32'h11080000, WR0=1, WDATA0=5 -> IOBUS_WR=1 and IOBUS_ADDR=32'h11080000.
REQ-037 REQ0 and REQ1 both rise in the same cycle from IDLE after reset -> GNT0 first; REQ0 drops -> GNT1 next cycle with no IDLE cycle; next simultaneous tie -> GNT0.
REQ-038 REQ1=1 with WR1=1 while GNT0 held -> IOBUS_WR follows WR0 only; IOBUS_ADDR never shows ADDR1.
REQ-039 IOBUS_IN=32'h0000BEEF with IOBUS_ADDR=32'h11000000 -> RDATA=32'h0000BEEF in the same cycle.
REQ-040 With IOBUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: REQ0 held, REQ1 raised -> forced switch to GNT1 after 8 contended cycles with a one-cycle TIMEOUT pulse; without the macro -> GNT0 held for 1000 cycles and TIMEOUT=0.
REQ-041 RESET_N pulled low mid-write in OWN1 -> GNT1 and IOBUS_WR go to 0 before the next edge; after release, REQ1=1 alone -> GNT1 two edges later.
